// File: rtl/lpf_pkg.sv
// Shared definitions for the LPF decimation controller.
//   DATA_W   : sample width of the filter input/output (signed)
//   TAPS     : filter length; a flush injects this many zero samples
//   FILT_LAT : cycles from filt_en rising to filt_dout being captured
//   state_t  : controller FSM state encoding
package lpf_pkg;

  localparam int DATA_W   = 10;
  localparam int TAPS     = 32;
  localparam int FILT_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/lpf_out_fifo.sv
// Synchronous show-ahead FIFO holding decimated filter outputs.
//   clk, reset : clock and asynchronous active-high reset
//   push       : write push_data (caller guarantees the FIFO is not full)
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry, 0 when empty
//   count      : number of stored entries (0..DEPTH)
//   empty      : no entries stored
module lpf_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_pop;

  assign empty  = (count_reg == '0);
  assign do_pop = pop && !empty;
  assign count  = count_reg;
  // Masking the head keeps out_data at 0 while empty, including after reset,
  // without having to reset the storage array.
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage is not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/lpf_decim_ctrl.sv
// Sequencing controller for the 32-tap LPF: feeds samples to the filter,
// decimates its output by DECIM and buffers results in an output FIFO.
// A flush drains the filter delay line with TAPS zero samples.
//   clk, reset                    : clock, asynchronous active-high reset
//   start, flush                  : control pulses (IDLE->RUN, RUN->FLUSH)
//   in_valid/in_ready/in_data     : signed input sample stream
//   filt_en, filt_din             : registered drive to the filter
//   filt_dout                     : filter output (combinational)
//   out_valid/out_ready/out_data  : decimated output stream (FIFO head)
//   busy                          : not IDLE, or FIFO holds data
//   flush_done                    : one-cycle pulse in first IDLE after flush
module lpf_decim_ctrl
  import lpf_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              filt_en,
  output logic [DATA_W-1:0] filt_din,
  input  logic [DATA_W-1:0] filt_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              flush_done
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam int PEND_W = $clog2(FILT_LAT + 1);
  localparam int PH_MAX = DECIM - 1;

  localparam logic [OCC_W-1:0] DEPTH_LIM  = FIFO_DEPTH[OCC_W-1:0];
  localparam logic [3:0]       PHASE_LAST = PH_MAX[3:0];
  localparam logic [5:0]       ZERO_LAST  = TAPS[5:0];

  state_t              state_reg;
  logic [3:0]          phase_reg;
  logic [5:0]          zero_cnt_reg;
  // Stage 0 is the filt_en cycle; the last stage is the capture cycle.
  logic [FILT_LAT-1:0] en_pipe_reg;
  logic [FILT_LAT-1:0] emit_pipe_reg;
  logic [DATA_W-1:0]   din_reg;
  logic                flush_done_reg;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_push;
  logic [PEND_W-1:0]   pending;
  logic [OCC_W-1:0]    occupied;
  logic                credit_ok;
  logic                accept;
  logic                inject;
  logic                issue;
  logic                emitting;
  logic                flush_exit;

  // Every in-flight sample holds a credit until its capture cycle, whether
  // or not it is emitting, so the FIFO can never be pushed while full.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FILT_LAT; i++) begin
      pending = pending + PEND_W'(en_pipe_reg[i]);
    end
  end

  assign occupied   = OCC_W'(fifo_count) + OCC_W'(pending);
  assign credit_ok  = (occupied < DEPTH_LIM);
  assign in_ready   = (state_reg == RUN) && credit_ok;
  assign accept     = in_ready && in_valid;
  assign inject     = (state_reg == FLUSH) && (zero_cnt_reg != ZERO_LAST) && credit_ok;
  assign issue      = accept || inject;
  assign emitting   = (phase_reg == PHASE_LAST);
  assign flush_exit = (state_reg == FLUSH) && (zero_cnt_reg == ZERO_LAST) && (pending == '0);
  assign fifo_push  = en_pipe_reg[FILT_LAT-1] && emit_pipe_reg[FILT_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      zero_cnt_reg   <= '0;
      en_pipe_reg    <= '0;
      emit_pipe_reg  <= '0;
      din_reg        <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      en_pipe_reg    <= {en_pipe_reg[FILT_LAT-2:0], issue};
      emit_pipe_reg  <= {emit_pipe_reg[FILT_LAT-2:0], issue && emitting};
      // Injected zeros and idle cycles both present 0 to the filter.
      din_reg        <= accept ? in_data : '0;
      flush_done_reg <= flush_exit;

      if (issue) begin
        phase_reg <= emitting ? 4'd0 : phase_reg + 4'd1;
      end
      if (inject) begin
        zero_cnt_reg <= zero_cnt_reg + 6'd1;
      end

      case (state_reg)
        IDLE: begin
          // start takes priority; flush is meaningless here.
          if (start) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state_reg    <= FLUSH;
            zero_cnt_reg <= '0;
          end
        end
        FLUSH: begin
          if (flush_exit) begin
            state_reg <= IDLE;
            phase_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign filt_en    = en_pipe_reg[0];
  assign filt_din   = din_reg;
  assign out_valid  = !fifo_empty;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign flush_done = flush_done_reg;

  lpf_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (filt_dout),
    .pop       (out_ready),
    .head_data (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_lpf_decim_ctrl.sv
// Testbench for lpf_decim_ctrl. Two instances (DECIM=1 and DECIM=4) each
// drive a behavioural 32-tap filter; one instance is exercised at a time.
module tb_lpf_decim_ctrl;
  import lpf_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset [N];
  logic       start [N];
  logic       flush [N];
  logic       in_valid [N];
  logic       in_ready [N];
  logic [9:0] in_data [N];
  logic       filt_en [N];
  logic [9:0] filt_din [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic [9:0] out_data [N];
  logic       busy [N];
  logic       flush_done [N];

  // Filter coefficients: DC gain 350/512.
  function automatic int coef(input int i);
    return (i == 0 || i == TAPS - 1) ? 10 : 11;
  endfunction

  function automatic int dec_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      logic signed [9:0] dl [TAPS] = '{default: '0};
      logic [9:0]        fdout;

      always @(posedge clk) begin
        if (filt_en[gi]) begin
          dl[0] <= filt_din[gi];
          for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
        end
      end

      always_comb begin
        int acc;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc = acc + int'(dl[i]) * coef(i);
        fdout = 10'(acc >>> 9);
      end

      lpf_decim_ctrl #(
        .DECIM      ((gi == 0) ? 1 : 4),
        .FIFO_DEPTH (4)
      ) u_dut (
        .clk        (clk),
        .reset      (reset[gi]),
        .start      (start[gi]),
        .flush      (flush[gi]),
        .in_valid   (in_valid[gi]),
        .in_ready   (in_ready[gi]),
        .in_data    (in_data[gi]),
        .filt_en    (filt_en[gi]),
        .filt_din   (filt_din[gi]),
        .filt_dout  (fdout),
        .out_valid  (out_valid[gi]),
        .out_ready  (out_ready[gi]),
        .out_data   (out_data[gi]),
        .busy       (busy[gi]),
        .flush_done (flush_done[gi])
      );
    end
  endgenerate

  // Reference model and scoreboard
  int mline [N][TAPS];
  int mphase [N];
  int mstate [N];   // 0 idle, 1 run, 2 flushing
  int exp_q [$];
  int s;
  int checks = 0;
  int errors = 0;
  int n_acc = 0, n_out = 0, n_zero = 0, n_done = 0, n_en = 0, last_out = 0;
  bit flushing = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_issue(input int k, input int v);
    int acc;
    for (int i = TAPS - 1; i > 0; i--) mline[k][i] = mline[k][i-1];
    mline[k][0] = v;
    if (mphase[k] == dec_of(k) - 1) begin
      acc = 0;
      for (int i = 0; i < TAPS; i++) acc = acc + mline[k][i] * coef(i);
      exp_q.push_back(acc >>> 9);
      mphase[k] = 0;
    end else begin
      mphase[k] = mphase[k] + 1;
    end
  endtask

  task automatic model_flush(input int k);
    for (int i = 0; i < TAPS; i++) model_issue(k, 0);
    mphase[k] = 0;
    mstate[k] = 2;
    flushing  = 1'b1;
  endtask

  // One clock: observe handshakes at the falling edge, then check the
  // registered filter drive just after the rising edge.
  task automatic tick();
    bit acc;
    bit popd;
    int dat;
    int e;
    @(negedge clk);
    acc  = in_valid[s] && in_ready[s];
    popd = out_valid[s] && out_ready[s];
    dat  = int'($signed(in_data[s]));
    if (popd) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", int'($signed(out_data[s])), 9999);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", int'($signed(out_data[s])), e);
        $display("dut%0d out %0d (exp %0d)", s, $signed(out_data[s]), e);
      end
      last_out = int'($signed(out_data[s]));
      n_out++;
    end
    if (acc) begin
      model_issue(s, dat);
      n_acc++;
    end
    if (mstate[s] == 0 && start[s]) mstate[s] = 1;
    else if (mstate[s] == 1 && flush[s]) model_flush(s);
    @(posedge clk);
    #1;
    if (filt_en[s]) n_en++;
    if (acc) begin
      check_eq("filt_en_lat", int'(filt_en[s]), 1);
      check_eq("filt_din", int'($signed(filt_din[s])), dat);
    end else if (flushing && filt_en[s]) begin
      n_zero++;
      check_eq("flush_din", int'($signed(filt_din[s])), 0);
    end
    if (flush_done[s]) begin
      n_done++;
      flushing  = 1'b0;
      mstate[s] = 0;
    end
  endtask

  task automatic pulse_start();
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
  endtask

  task automatic feed(input int cnt, input int v, output int cyc);
    int n0;
    n0  = n_acc;
    cyc = 0;
    in_valid[s] = 1'b1;
    in_data[s]  = 10'(v);
    while (n_acc - n0 < cnt && cyc < 500) begin
      tick();
      cyc++;
    end
    in_valid[s] = 1'b0;
  endtask

  task automatic drain();
    out_ready[s] = 1'b1;
    in_valid[s]  = 1'b0;
    repeat (30) tick();
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input int k, input string pfx);
    check_eq({pfx, "_in_ready"},   int'(in_ready[k]), 0);
    check_eq({pfx, "_filt_en"},    int'(filt_en[k]), 0);
    check_eq({pfx, "_filt_din"},   int'(filt_din[k]), 0);
    check_eq({pfx, "_out_valid"},  int'(out_valid[k]), 0);
    check_eq({pfx, "_out_data"},   int'(out_data[k]), 0);
    check_eq({pfx, "_busy"},       int'(busy[k]), 0);
    check_eq({pfx, "_flush_done"}, int'(flush_done[k]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0, d0, e0;
    for (int k = 0; k < N; k++) begin
      reset[k] = 1'b1; start[k] = 1'b0; flush[k] = 1'b0;
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
      mphase[k] = 0; mstate[k] = 0;
      for (int i = 0; i < TAPS; i++) mline[k][i] = 0;
    end
    s = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check_reset_outs(k, "rst");
    for (int k = 0; k < N; k++) reset[k] = 1'b0;
    #2;

    // DC response, DECIM=1
    s = 0; n_out = 0; out_ready[0] = 1'b1;
    pulse_start();
    feed(64, 100, cyc);
    check_eq("dc_cycles", cyc, 64);
    drain();
    check_eq("dc_outputs", n_out, 64);
    check_eq("dc_last", last_out, 68);

    // Decimation, DECIM=4
    s = 1; n_out = 0; out_ready[1] = 1'b1;
    pulse_start();
    feed(64, 100, cyc);
    check_eq("dec_cycles", cyc, 64);
    drain();
    check_eq("dec_outputs", n_out, 16);
    check_eq("dec_last", last_out, 68);

    // Backpressure, DECIM=1
    s = 0; n_out = 0; out_ready[0] = 1'b0;
    n0 = n_acc;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data[0] = 10'(10 + i);
      tick();
    end
    in_valid[0] = 1'b0;
    check_eq("bp_accepts", n_acc - n0, 4);
    check_eq("bp_in_ready", int'(in_ready[0]), 0);
    check_eq("bp_out_valid", int'(out_valid[0]), 1);
    drain();
    check_eq("bp_outputs", n_out, 4);

    // Flush with in_valid held high
    s = 0; n_out = 0; out_ready[0] = 1'b1;
    feed(40, -200, cyc);
    n_zero = 0; d0 = n_done;
    in_valid[0] = 1'b1; in_data[0] = 10'(-200); flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    check_eq("fl_in_ready", int'(in_ready[0]), 0);
    for (int i = 0; i < 300 && n_done == d0; i++) tick();
    repeat (5) tick();
    in_valid[0] = 1'b0;
    check_eq("fl_zeros", n_zero, 32);
    check_eq("fl_done", n_done - d0, 1);
    drain();
    check_eq("fl_last", last_out, 0);
    check_eq("fl_idle_ready", int'(in_ready[0]), 0);
    check_eq("fl_idle_busy", int'(busy[0]), 0);

    // Control corners on DECIM=4 instance (currently RUN)
    s = 1; out_ready[1] = 1'b1;
    pulse_start();
    check_eq("start_in_run", int'(in_ready[1]), 1);
    d0 = n_done;
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    for (int i = 0; i < 300 && n_done == d0; i++) tick();
    drain();
    check_eq("c_flush_done", n_done - d0, 1);
    e0 = n_en;
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    repeat (3) tick();
    check_eq("idle_flush_ready", int'(in_ready[1]), 0);
    check_eq("idle_flush_busy", int'(busy[1]), 0);
    check_eq("idle_flush_en", n_en - e0, 0);
    start[1] = 1'b1; flush[1] = 1'b1;
    tick();
    start[1] = 1'b0; flush[1] = 1'b0;
    check_eq("start_wins_ready", int'(in_ready[1]), 1);
    repeat (5) tick();
    check_eq("start_wins_no_inject", n_en - e0, 0);
    check_eq("start_wins_busy", int'(busy[1]), 1);

    // Reset in the middle of a flush
    feed(8, 50, cyc);
    n_zero = 0; d0 = n_done;
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    for (int i = 0; i < 100 && n_zero < 10; i++) tick();
    check_eq("mid_zeros", n_zero, 10);
    reset[1] = 1'b1;
    #1;
    check_reset_outs(1, "mid_rst");
    exp_q.delete();
    mphase[1] = 0; mstate[1] = 0; flushing = 1'b0;
    tick();
    tick();
    reset[1] = 1'b0;
    repeat (60) tick();
    check_eq("mid_no_done", n_done - d0, 0);
    check_eq("mid_busy", int'(busy[1]), 0);
    check_eq("mid_out_valid", int'(out_valid[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpf_decim_ctrl.md
# lpf_decim_ctrl

Sequencing controller for the 32-tap low-pass FIR (`LPF_Filter`, 10-bit signed in/out, one shift per `clk_enable` pulse). It accepts input samples over a valid/ready handshake and drives the filter's sample enable and data input. It decimates the filter output by `DECIM` and buffers the results in a small output FIFO with valid/ready. It also owns start/flush sequencing: a flush drains the filter delay line with 32 zero samples and then returns to idle.

## Interface
- `DECIM`, 4: decimation factor. Legal range is 1..16.
- `FIFO_DEPTH`, 4: output FIFO depth. Must be a power of two and at least 4.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; moves IDLE to RUN.
- `flush` in 1: pulse; moves RUN to FLUSH.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 10: signed input sample stream.
- `filt_en` out 1: registered; drives the filter `clk_enable`.
- `filt_din` out 10: registered; drives the filter `filter_din`.
- `filt_dout` in 10: filter output, combinational from the filter delay line.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 10: decimated output stream from the FIFO head.
- `busy` out 1: high when the state is not IDLE or the FIFO is non-empty.
- `flush_done` out 1: one-cycle pulse on the FLUSH-to-IDLE transition.

## Operation
- **States:**
  - IDLE: `in_ready` = 0.
  - RUN: accepts samples.
  - FLUSH: `in_ready` = 0; the controller injects zeros internally.
- **Transitions:**
  - IDLE goes to RUN on `start`. `flush` in IDLE is ignored.
  - RUN goes to FLUSH on `flush`. `start` in RUN is ignored.
  - If `start` and `flush` arrive in the same cycle in IDLE, `start` wins.
  - FLUSH goes to IDLE once the zero counter reaches 32 and no outputs are in flight.
- **Credit rule:**
  - `occupied` = FIFO count + pending, where pending (0..2) counts enabled samples whose output has not yet been written to the FIFO.
  - A sample may issue (input handshake in RUN, or zero injection in FLUSH) only when `occupied` < `FIFO_DEPTH`.
  - Every issued sample takes one credit, whether or not it produces an output. This rule is conservative, so FIFO overflow is impossible by construction.
- **Issue:**
  - An issued sample sets `filt_en` = 1 and `filt_din` = sample on the next edge, for exactly one cycle.
  - In FLUSH, `filt_din` = 0.
  - At most one issue per cycle.
- **Decimation:**
  - The phase counter runs 0..`DECIM`-1 and advances on each issue.
  - The sample issued at phase `DECIM`-1 is "emitting"; the phase then wraps to 0.
  - `DECIM` = 1 makes every sample emitting.
  - The phase resets to 0 on entry to IDLE.
- **Capture:** two cycles after an emitting issue, `filt_dout` is written into the FIFO. Non-emitting samples release their credit at that same point.
- **FIFO:**
  - Pop happens when `out_valid` and `out_ready` are both high.
  - Push and pop in the same cycle keeps the count unchanged.
  - `out_data` shows the head entry.
- **Zero counter:** 6-bit, counts injected zeros in FLUSH, and clears on entry to FLUSH.
- **Data width:** data is passed through unmodified at 10-bit signed; the controller performs no arithmetic on samples.
- **Reset:**
  - At any time, including mid-FLUSH, reset returns all state to reset values and discards FIFO contents and in-flight samples.
  - The filter delay line is not cleared by this block.

## Timing
- **Reset values:** state IDLE, `in_ready` 0, `filt_en` 0, `filt_din` 0, `out_valid` 0, `out_data` 0, `busy` 0, `flush_done` 0.
- **Latency:**
  - Handshake at edge t gives `filt_en` high during cycle t+1.
  - The filter shifts at t+1.
  - `filt_dout` is valid in cycle t+2 and captured at edge t+2.
  - `out_valid` rises in cycle t+3 if the FIFO was empty.
- **Throughput:** with `out_ready` held at 1, one sample is accepted per cycle with no bubbles.
- **`in_ready`:** combinational from state and `occupied`. It never depends on `in_valid`.
- **`flush_done`:** asserts in the first IDLE cycle. `busy` may remain high until the FIFO drains.

## Structure
- Shared package `lpf_pkg`:
  - `DATA_W` = 10, `TAPS` = 32, `FILT_LAT` = 2.
  - State enum {IDLE, RUN, FLUSH}.
- One sub-module, `lpf_out_fifo`: synchronous FIFO, parameterised depth and width, exposing push/pop/count.
- The filter is instantiated by the parent, not inside this block.

## Test plan
- **DC response:** `DECIM`=1, start, then 64 samples of +100 with `out_ready`=1. Required: 64 outputs; from output 33 onward each equals 68 (100 × 350 >> 9); none are lost.
- **Decimation:** `DECIM`=4, 64 samples of +100. Required: exactly 16 outputs; the last 8 equal 68; one output per 4 accepted samples.
- **Backpressure:** `DECIM`=1, `out_ready`=0, `in_valid` held high. Required: `in_ready` drops after exactly 4 accepts; FIFO holds 4 entries. Raise `out_ready`: all entries drain in order and no sample is lost or duplicated.
- **Flush:** after 40 samples of −200, pulse `flush` while `in_valid`=1. Required: `in_ready`=0 immediately; 32 `filt_en` pulses with `filt_din`=0; final outputs equal 0; `flush_done` pulses once; state returns to IDLE.
- **Control corner cases:** `start` and `flush` in the same IDLE cycle gives RUN. `flush` in IDLE gives no effect. `start` in RUN gives no effect.
- **Reset mid-FLUSH:** assert `reset` after 10 injected zeros. Required: all outputs at reset values within the same cycle; FIFO empty; `flush_done` never pulses.
